// File: rtl/vga_scan_if.sv
// Scan-side bundle between the VGA timing generator and the colour mask.
// The master drives the pixel position and the video outputs. The slave returns the colour for that position.
interface vga_scan_if;
    logic [9:0] px;
    logic [9:0] py;
    logic [2:0] col;
    logic [2:0] rgb;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;

    modport master (
        output px, py, rgb, hsync, vsync, video_on, frame_start,
        input  col
    );

    modport slave (
        input  px, py, rgb, hsync, vsync, video_on, frame_start,
        output col
    );
endinterface

// File: rtl/vga_scan.sv
// VGA raster generator. It drives px/py and samples col on each pixel tick.
// rgb, syncs and video_on appear one tick after their px/py. There is no backpressure: col is only sampled on the tick.
module vga_scan #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    vga_scan_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_LO   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic          tick;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;

    assign tick   = (div == DIV_LAST);
    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);
    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_raw = !((hcnt >= HS_LO) && (hcnt < HS_HI));
    assign vs_raw = !((vcnt >= VS_LO) && (vcnt < VS_HI));

    assign vif.px = hcnt;
    assign vif.py = vcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (h_last) begin
                    hcnt <= '0;
                    vcnt <= v_last ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // All outputs reflect the counters as they were before this tick's advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vif.rgb         <= 3'b000;
            vif.hsync       <= 1'b1;
            vif.vsync       <= 1'b1;
            vif.video_on    <= 1'b0;
            vif.frame_start <= 1'b0;
        end else begin
            vif.frame_start <= tick && h_last && v_last;
            if (tick) begin
                vif.rgb      <= active ? vif.col : 3'b000;
                vif.hsync    <= hs_raw;
                vif.vsync    <= vs_raw;
                vif.video_on <= active;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan.sv
// Randomized scoreboard bench for vga_scan on a scaled-down raster.
// A position-arithmetic model predicts every clock's outputs. A monitor pops the predictions and compares them.
module tb_vga_scan;
    localparam int D  = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         mode = 0;
    logic [2:0] col_r = 3'b000;
    int         total = 0;
    int         bad = 0;
    int         n_rec = 0;
    rec_t       exp_q[$];
    int         m_px = 0;
    int         m_py = 0;

    vga_scan_if vif ();

    vga_scan #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    assign vif.col = (mode == 1) ? vif.px[2:0] : (mode == 2) ? 3'b111 : col_r;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        col_r = 3'($urandom_range(0, 7));
    end

    // Reference model: the position follows from the count of elapsed ticks since reset.
    initial begin : model
        int   n, t, q, h, v;
        logic act;
        rec_t r;
        logic [2:0] s_rgb;
        logic s_hs, s_vs, s_von;
        n = 0;
        s_rgb = 3'b000; s_hs = 1'b1; s_vs = 1'b1; s_von = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0;
                s_rgb = 3'b000; s_hs = 1'b1; s_vs = 1'b1; s_von = 1'b0;
                m_px = 0; m_py = 0;
            end else begin
                n++;
                t = n / D;
                if (n % D == 0) begin
                    q   = t - 1;
                    h   = q % HT;
                    v   = (q / HT) % VT;
                    act = (h < HA) && (v < VA);
                    s_von = act;
                    s_hs  = !(h >= HA + HF && h < HA + HF + HS);
                    s_vs  = !(v >= VA + VF && v < VA + VF + VS);
                    if (!act)           s_rgb = 3'b000;
                    else if (mode == 1) s_rgb = 3'(h % 8);
                    else if (mode == 2) s_rgb = 3'b111;
                    else                s_rgb = col_r;
                end
                m_px = t % HT;
                m_py = (t / HT) % VT;
                r.px  = 10'(m_px);
                r.py  = 10'(m_py);
                r.rgb = s_rgb;
                r.hs  = s_hs;
                r.vs  = s_vs;
                r.von = s_von;
                r.fs  = (n % D == 0) && (t % FT == 0);
                exp_q.push_back(r);
            end
        end
    end

    // Monitor: per-clock record compare plus sync-width and frame-period trackers.
    initial begin : monitor
        rec_t e, a;
        int hs_run, vs_run, cyc, last_fs;
        hs_run = 0; vs_run = 0; cyc = 0; last_fs = -1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                hs_run = 0; vs_run = 0; last_fs = -1;
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{vif.px, vif.py, vif.rgb, vif.hsync, vif.vsync, vif.video_on, vif.frame_start};
                n_rec++;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scan: got px=%0d py=%0d rgb=%0d hs=%b vs=%b von=%b fs=%b expected px=%0d py=%0d rgb=%0d hs=%b vs=%b von=%b fs=%b at %0t",
                             a.px, a.py, a.rgb, a.hs, a.vs, a.von, a.fs,
                             e.px, e.py, e.rgb, e.hs, e.vs, e.von, e.fs, $time);
                end
                if (!vif.hsync) hs_run++;
                else if (hs_run > 0) begin chk("hsync_width", hs_run, HS * D); hs_run = 0; end
                if (!vif.vsync) vs_run++;
                else if (vs_run > 0) begin chk("vsync_width", vs_run, VS * HT * D); vs_run = 0; end
                if (vif.frame_start) begin
                    if (last_fs >= 0) chk("frame_period", cyc - last_fs, FT * D);
                    last_fs = cyc;
                end
            end
        end
    end

    initial begin : main
        bit found;
        #1 rst = 1'b1;
        #1;
        chk("reset_px", int'(vif.px), 0);
        chk("reset_py", int'(vif.py), 0);
        chk("reset_rgb", int'(vif.rgb), 0);
        chk("reset_hsync", int'(vif.hsync), 1);
        chk("reset_vsync", int'(vif.vsync), 1);
        chk("reset_video_on", int'(vif.video_on), 0);
        chk("reset_frame_start", int'(vif.frame_start), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        mode = 0;
        repeat (2 * FT * D + 7) @(negedge clk);

        // Reset in the middle of a line during hsync, away from any clock edge.
        found = 1'b0;
        for (int i = 0; i < 4 * FT * D && !found; i++) begin
            @(negedge clk);
            if (m_px == HA + HF + 1 && m_py == 3) found = 1'b1;
        end
        chk("midline_reached", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_px", int'(vif.px), 0);
        chk("mid_reset_py", int'(vif.py), 0);
        chk("mid_reset_hsync", int'(vif.hsync), 1);
        chk("mid_reset_vsync", int'(vif.vsync), 1);
        chk("mid_reset_rgb", int'(vif.rgb), 0);
        chk("mid_reset_video_on", int'(vif.video_on), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mode = 1;
        repeat (2 * FT * D + 11) @(negedge clk);
        mode = 2;
        repeat (2 * FT * D + 5) @(negedge clk);
        mode = 0;
        repeat (FT * D) @(negedge clk);

        chk("records_checked", int'(n_rec >= 6 * FT * D), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per pixel tick (50 MHz clk -> 25 MHz pixel rate).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33; H_TOTAL = sum of the four H values (800), V_TOTAL = sum of the four V values (525).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 px  output  10  current horizontal counter, driven to the background/sprite mask lookups.
REQ-007 py  output  10  current vertical counter, driven to the mask lookups.
REQ-008 col  input  3  combinational colour returned by the mask for the current px/py.
REQ-009 rgb  output  3  registered pixel colour to the DAC pins, same bit order as col.
REQ-010 hsync  output  1  horizontal sync, active low, registered.
REQ-011 vsync  output  1  vertical sync, active low, registered.
REQ-012 video_on  output  1  registered active-area flag, aligned with rgb.
REQ-013 frame_start  output  1  one-clk pulse marking the start of each frame.

Function
REQ-014 SHALL contain a divider counter div, 0..CLK_DIV-1, incrementing every clk; tick = (div == CLK_DIV-1); div wraps to 0 after tick; CLK_DIV=1 gives tick every clk.
REQ-015 SHALL advance hcnt by 1 only on tick; at hcnt == H_TOTAL-1 with tick, hcnt wraps to 0 and vcnt advances by 1.
REQ-016 SHALL wrap vcnt to 0 when hcnt wraps while vcnt == V_TOTAL-1; counters never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-017 SHALL drive px = hcnt and py = vcnt directly from the counter registers (no added latency), stable between ticks.
REQ-018 SHALL compute active = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE).
REQ-019 SHALL compute hs_raw low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751), else high.
REQ-020 SHALL compute vs_raw low for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), else high.
REQ-021 SHALL, on each tick, register rgb <= active ? col : 3'b000, hsync <= hs_raw, video_on <= active, vsync <= vs_raw, all sampled from the counter values before the tick's increment; outputs hold between ticks.
REQ-022 SHALL therefore present rgb/hsync/vsync/video_on exactly one pixel tick after the px/py that produced them; the three sync/flag outputs and rgb are mutually aligned.
REQ-023 SHALL force rgb to 000 whenever the registered video_on is 0, regardless of col.
REQ-024 SHALL assert frame_start for exactly one clk cycle, the cycle following the tick on which (hcnt, vcnt) wraps from (H_TOTAL-1, V_TOTAL-1) to (0, 0); never asserted otherwise.
REQ-025 SHALL treat col as valid only during the clk cycle of the tick; col changes between ticks have no effect.

Reset
REQ-026 SHALL, while rst is high, asynchronously set div=0, hcnt=0, vcnt=0, rgb=000, hsync=1, vsync=1, video_on=0, frame_start=0.
REQ-027 SHALL, after rst deasserts, produce the first tick CLK_DIV clk cycles later; rst mid-frame abandons the frame and restarts at (0,0) with no frame_start pulse for the restart.

Verification
REQ-028 Reset: assert rst mid-line at hcnt=300 -> px=0, py=0, hsync=vsync=1, rgb=000, video_on=0 immediately, without a clock edge.
REQ-029 Line timing (CLK_DIV=2): hsync low for exactly 96 ticks (192 clk) per line, falling one tick after px=656; line period 1600 clk.
REQ-030 Frame timing: vsync low for exactly 2 lines (1600 ticks), starting one tick after py=490; frame_start period 800*525*2 = 840000 clk, one pulse per frame.
REQ-031 Blanking: col tied to 3'b111 -> rgb=111 only for 640x480 ticks per frame, rgb=000 at px=640..799 and py=480..524.
REQ-032 Latency: col driven as function of px (col = px[2:0]) -> rgb at tick n equals px[2:0] at tick n-1 within active area.
REQ-033 Wrap: observe (799,524) -> (0,0) transition -> py wraps without skipping, frame_start high one clk, video_on rises one tick after px=0, py=0.
